multi_dataflow_tile_sequencer: RTL and testbench
================================================

// Module: multi_dataflow_tile_sequencer
// PURPOSE
//  Top-level control FSM of the multi_dataflow HWPE. Sits between the register file and the streamer/engine.
//  Runs NB_ITER tiles. Per tile: issues one request to each stream (in_pel, in_size, out_pel), starts the
//  engine, then waits for engine and stream completion. Advances stream base addresses by the tile stride
//  after each tile and raises done when the last tile ends.
// PARAMETERS
//  ADDR_W     32  width of stream base addresses and tile stride
//  NB_ITER_W  16  width of iteration count / index
//  CNT_W      11  engine output counter width ($clog2(1024)+1)
// PORTS
//  clk_i            in   1          clock
//  clear_i          in   1          reset, synchronous, active-high
//  start_i          in   1          job trigger pulse from register file
//  nb_iter_i        in   NB_ITER_W  tiles per job; 0 treated as 1
//  tile_stride_i    in   ADDR_W     byte offset added to all bases per tile
//  cnt_limit_i      in   CNT_W      expected out_pel count per tile
//  in_pel_base_i    in   ADDR_W     in_pel base address, tile 0
//  in_size_base_i   in   ADDR_W     in_size base address, tile 0
//  out_pel_base_i   in   ADDR_W     out_pel base address, tile 0
//  strm_ready_i     in   3          stream ready [0]=in_pel [1]=in_size [2]=out_pel
//  strm_done_i      in   3          stream done pulses, same bit order
//  strm_req_o       out  3          stream request pulses, same bit order
//  in_pel_addr_o    out  ADDR_W     current in_pel address
//  in_size_addr_o   out  ADDR_W     current in_size address
//  out_pel_addr_o   out  ADDR_W     current out_pel address
//  eng_start_o      out  1          engine start pulse
//  eng_enable_o     out  1          engine enable
//  eng_clear_o      out  1          engine clear pulse
//  eng_done_i       in   1          engine done pulse
//  cnt_out_i        in   CNT_W      engine out_pel counter
//  iter_idx_o       out  NB_ITER_W  index of current tile
//  busy_o           out  1          high whenever state != IDLE
//  done_o           out  1          one-cycle pulse at job end
//  cnt_err_o        out  1          sticky: cnt_out_i != limit at an engine done
// BEHAVIOUR
//  Reset: clear_i=1 at a clock edge forces IDLE and zeroes all regs and outputs, in any state.
//   An aborted job never pulses done_o.
//  States: IDLE, START, COMPUTE, WAIT, UPDATEIDX, TERMINATE. All outputs are registered or decoded from state.
//  IDLE: on start_i=1, latch nb_iter (0->1), cnt_limit and the three bases into the address regs.
//   Also clear iter_idx and cnt_err. Next state START.
//  START: hold until strm_ready_i==3'b111. In that cycle, pulse strm_req_o=3'b111 and eng_start_o=1
//   for exactly 1 cycle, then go to COMPUTE.
//  COMPUTE: eng_enable_o=1. Each strm_done_i bit sets a sticky done bit.
//   On eng_done_i: set cnt_err_o if cnt_out_i != cnt_limit, then go to WAIT.
//  WAIT: eng_enable_o=1. Keep collecting sticky done bits; go to UPDATEIDX when all 3 are set.
//   Done bits set in the same cycle as eng_done_i count, so COMPUTE->WAIT->UPDATEIDX is the minimum path.
//  UPDATEIDX: 1 cycle. Clear sticky bits; iter_idx += 1; each address += tile_stride (modulo 2^ADDR_W).
//   If iter_idx+1 == nb_iter, go to TERMINATE, else START.
//  TERMINATE: 1 cycle. Pulse done_o=1 and eng_clear_o=1, then go to IDLE.
//   busy_o drops in the cycle after the done_o pulse.
//  start_i is ignored when not in IDLE. Done pulses received in IDLE or START are ignored.
//  Addresses hold their value between updates; after a job they hold the final tile's address + stride.
//  iter_idx holds its final value until the next start.
//  Latency, 1 tile, all ready, dones arriving with eng_done_i: start_i @0, req @2, done_o @ eng_done+3.
// TESTING
//  nb_iter=1, ready=111, engine done 5 cycles after start, all strm_done with it
//   -> exactly 1 req pulse per stream, done_o exactly once, busy_o low afterwards.
//  nb_iter=3, stride=0x100, bases 0x1000/0x2000/0x3000 -> req-cycle addresses x000, x100, x200;
//   iter_idx_o 0,1,2; one done_o.
//  strm_ready=101 held 4 cycles, then 111 -> no req and no eng_start until ready=111; then exactly 1 pulse.
//  out_pel done arrives 6 cycles after eng_done -> stays in WAIT with eng_enable_o=1, then UPDATEIDX next cycle.
//  nb_iter=0 -> behaves as 1 tile. cnt_out=9 with limit=10 -> cnt_err_o=1 until next start.
//  clear_i in COMPUTE of tile 1 of 3 -> IDLE next cycle, all outputs 0, no done_o;
//   a new start then runs cleanly from the bases.

Source files
------------

// File: rtl/multi_dataflow_tile_sequencer.sv
// Tile-level control FSM for the multi_dataflow HWPE: issues per-tile stream requests,
// starts the engine, collects completions and advances the stream base addresses.
module multi_dataflow_tile_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int NB_ITER_W = 16,
  parameter int CNT_W     = 11
) (
  input  logic                 clk_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [NB_ITER_W-1:0] nb_iter_i,
  input  logic [ADDR_W-1:0]    tile_stride_i,
  input  logic [CNT_W-1:0]     cnt_limit_i,
  input  logic [ADDR_W-1:0]    in_pel_base_i,
  input  logic [ADDR_W-1:0]    in_size_base_i,
  input  logic [ADDR_W-1:0]    out_pel_base_i,
  input  logic [2:0]           strm_ready_i,
  input  logic [2:0]           strm_done_i,
  output logic [2:0]           strm_req_o,
  output logic [ADDR_W-1:0]    in_pel_addr_o,
  output logic [ADDR_W-1:0]    in_size_addr_o,
  output logic [ADDR_W-1:0]    out_pel_addr_o,
  output logic                 eng_start_o,
  output logic                 eng_enable_o,
  output logic                 eng_clear_o,
  input  logic                 eng_done_i,
  input  logic [CNT_W-1:0]     cnt_out_i,
  output logic [NB_ITER_W-1:0] iter_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cnt_err_o
);

  typedef enum logic [2:0] {
    IDLE, START, COMPUTE, WAIT, UPDATEIDX, TERMINATE
  } state_t;

  state_t               state, state_nxt;
  logic [NB_ITER_W-1:0] nb_iter;
  logic [CNT_W-1:0]     cnt_limit;
  logic [2:0]           sticky;
  logic [2:0]           done_all;
  logic                 last_tile;

  // A zero iteration count still runs one tile.
  function automatic logic [NB_ITER_W-1:0] norm_nb_iter(input logic [NB_ITER_W-1:0] n);
    return (n == '0) ? NB_ITER_W'(1) : n;
  endfunction

  // Done bits arriving this cycle count as already collected.
  assign done_all  = sticky | strm_done_i;
  assign last_tile = ((iter_idx_o + NB_ITER_W'(1)) == nb_iter);

  always_ff @(posedge clk_i) begin
    if (clear_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_i) state_nxt = START;
      START:     if (&strm_ready_i) state_nxt = COMPUTE;
      COMPUTE:   if (eng_done_i) state_nxt = WAIT;
      WAIT:      if (&done_all) state_nxt = UPDATEIDX;
      UPDATEIDX: state_nxt = last_tile ? TERMINATE : START;
      TERMINATE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign busy_o       = (state != IDLE);
  assign eng_enable_o = (state == COMPUTE) || (state == WAIT);
  assign done_o       = (state == TERMINATE);
  assign eng_clear_o  = (state == TERMINATE);

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      nb_iter        <= '0;
      cnt_limit      <= '0;
      sticky         <= '0;
      iter_idx_o     <= '0;
      cnt_err_o      <= 1'b0;
      strm_req_o     <= '0;
      eng_start_o    <= 1'b0;
      in_pel_addr_o  <= '0;
      in_size_addr_o <= '0;
      out_pel_addr_o <= '0;
    end else begin
      strm_req_o  <= '0;
      eng_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            nb_iter        <= norm_nb_iter(nb_iter_i);
            cnt_limit      <= cnt_limit_i;
            in_pel_addr_o  <= in_pel_base_i;
            in_size_addr_o <= in_size_base_i;
            out_pel_addr_o <= out_pel_base_i;
            iter_idx_o     <= '0;
            cnt_err_o      <= 1'b0;
            sticky         <= '0;
          end
        end
        START: begin
          if (&strm_ready_i) begin
            strm_req_o  <= 3'b111;
            eng_start_o <= 1'b1;
          end
        end
        COMPUTE: begin
          sticky <= done_all;
          if (eng_done_i && (cnt_out_i != cnt_limit)) cnt_err_o <= 1'b1;
        end
        WAIT: sticky <= done_all;
        UPDATEIDX: begin
          sticky         <= '0;
          iter_idx_o     <= iter_idx_o + NB_ITER_W'(1);
          in_pel_addr_o  <= in_pel_addr_o + tile_stride_i;
          in_size_addr_o <= in_size_addr_o + tile_stride_i;
          out_pel_addr_o <= out_pel_addr_o + tile_stride_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_dataflow_tile_sequencer.sv
// Directed bench for multi_dataflow_tile_sequencer: hand-computed expectations checked
// with immediate assertions, one linear stimulus sequence.
module tb_multi_dataflow_tile_sequencer;

  logic        clk = 1'b0;
  logic        clear_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] nb_iter_i = '0;
  logic [31:0] tile_stride_i = 32'h100;
  logic [10:0] cnt_limit_i = 11'd10;
  logic [31:0] in_pel_base_i = 32'h1000;
  logic [31:0] in_size_base_i = 32'h2000;
  logic [31:0] out_pel_base_i = 32'h3000;
  logic [2:0]  strm_ready_i = 3'b111;
  logic [2:0]  strm_done_i = '0;
  logic [2:0]  strm_req_o;
  logic [31:0] in_pel_addr_o, in_size_addr_o, out_pel_addr_o;
  logic        eng_start_o, eng_enable_o, eng_clear_o;
  logic        eng_done_i = 1'b0;
  logic [10:0] cnt_out_i = '0;
  logic [15:0] iter_idx_o;
  logic        busy_o, done_o, cnt_err_o;

  int checks = 0;
  int errors = 0;
  int req0 = 0, req1 = 0, req2 = 0, done_cnt = 0, start_cnt = 0;

  always #5 clk = ~clk;

  multi_dataflow_tile_sequencer #(.ADDR_W(32), .NB_ITER_W(16), .CNT_W(11)) dut (
    .clk_i(clk), .clear_i(clear_i), .start_i(start_i), .nb_iter_i(nb_iter_i),
    .tile_stride_i(tile_stride_i), .cnt_limit_i(cnt_limit_i),
    .in_pel_base_i(in_pel_base_i), .in_size_base_i(in_size_base_i),
    .out_pel_base_i(out_pel_base_i), .strm_ready_i(strm_ready_i),
    .strm_done_i(strm_done_i), .strm_req_o(strm_req_o),
    .in_pel_addr_o(in_pel_addr_o), .in_size_addr_o(in_size_addr_o),
    .out_pel_addr_o(out_pel_addr_o), .eng_start_o(eng_start_o),
    .eng_enable_o(eng_enable_o), .eng_clear_o(eng_clear_o),
    .eng_done_i(eng_done_i), .cnt_out_i(cnt_out_i), .iter_idx_o(iter_idx_o),
    .busy_o(busy_o), .done_o(done_o), .cnt_err_o(cnt_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; pulse counters see every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (strm_req_o[0]) req0++;
    if (strm_req_o[1]) req1++;
    if (strm_req_o[2]) req2++;
    if (done_o) done_cnt++;
    if (eng_start_o) start_cnt++;
  endtask

  task automatic clr_counts();
    req0 = 0; req1 = 0; req2 = 0; done_cnt = 0; start_cnt = 0;
  endtask

  task automatic kick(input logic [15:0] n);
    nb_iter_i = n;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Called in a START cycle with ready=111; returns in the cycle after UPDATEIDX.
  task automatic do_tile(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                         input logic [15:0] eidx, input int lat, input logic [10:0] cnt);
    step();
    chk("req", strm_req_o, 3'b111);
    chk("eng_start", eng_start_o, 1'b1);
    chk("enable_compute", eng_enable_o, 1'b1);
    chk("in_pel_addr", in_pel_addr_o, ea);
    chk("in_size_addr", in_size_addr_o, eb);
    chk("out_pel_addr", out_pel_addr_o, ec);
    chk("iter_idx", iter_idx_o, eidx);
    repeat (lat) step();
    eng_done_i = 1'b1;
    strm_done_i = 3'b111;
    cnt_out_i = cnt;
    step();
    eng_done_i = 1'b0;
    strm_done_i = 3'b000;
    chk("enable_wait", eng_enable_o, 1'b1);
    step();
    chk("enable_update", eng_enable_o, 1'b0);
    chk("busy_update", busy_o, 1'b1);
    step();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(); step();
    clear_i = 1'b0;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_req", strm_req_o, 3'b000);
    chk("rst_enable", eng_enable_o, 1'b0);
    chk("rst_addr", in_pel_addr_o, 32'h0);
    chk("rst_idx", iter_idx_o, 16'h0);
    chk("rst_cnt_err", cnt_err_o, 1'b0);

    // Single tile, engine done 5 cycles after start
    clr_counts();
    kick(16'd1);
    chk("A_busy_start", busy_o, 1'b1);
    chk("A_no_req_yet", strm_req_o, 3'b000);
    chk("A_latched", in_pel_addr_o, 32'h1000);
    do_tile(32'h1000, 32'h2000, 32'h3000, 16'd0, 5, 11'd10);
    chk("A_done", done_o, 1'b1);
    chk("A_eng_clear", eng_clear_o, 1'b1);
    chk("A_busy_term", busy_o, 1'b1);
    step();
    chk("A_busy_after", busy_o, 1'b0);
    chk("A_done_after", done_o, 1'b0);
    step(); step();
    chk("A_req0", req0, 1);
    chk("A_req1", req1, 1);
    chk("A_req2", req2, 1);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_final_addr", out_pel_addr_o, 32'h3100);
    chk("A_final_idx", iter_idx_o, 16'd1);
    chk("A_cnt_err", cnt_err_o, 1'b0);

    // Three tiles with stride 0x100
    clr_counts();
    kick(16'd3);
    do_tile(32'h1000, 32'h2000, 32'h3000, 16'd0, 2, 11'd10);
    chk("B_back_to_start", done_o, 1'b0);
    do_tile(32'h1100, 32'h2100, 32'h3100, 16'd1, 2, 11'd10);
    do_tile(32'h1200, 32'h2200, 32'h3200, 16'd2, 2, 11'd10);
    chk("B_done", done_o, 1'b1);
    step();
    chk("B_idle", busy_o, 1'b0);
    chk("B_in_pel_final", in_pel_addr_o, 32'h1300);
    chk("B_in_size_final", in_size_addr_o, 32'h2300);
    chk("B_out_pel_final", out_pel_addr_o, 32'h3300);
    chk("B_idx_final", iter_idx_o, 16'd3);
    chk("B_done_cnt", done_cnt, 1);
    chk("B_req_cnt", req0 + req1 + req2, 9);

    // Streams not all ready for 4 cycles
    clr_counts();
    strm_ready_i = 3'b101;
    kick(16'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("C_no_req", strm_req_o, 3'b000);
      chk("C_no_start", eng_start_o, 1'b0);
      chk("C_stall_busy", busy_o, 1'b1);
    end
    strm_ready_i = 3'b111;
    do_tile(32'h1000, 32'h2000, 32'h3000, 16'd0, 1, 11'd10);
    chk("C_done", done_o, 1'b1);
    step();
    chk("C_req_once", req0 + req1 + req2, 3);
    chk("C_start_once", start_cnt, 1);

    // out_pel done arrives 6 cycles after eng_done
    clr_counts();
    kick(16'd1);
    step();
    chk("D_req", strm_req_o, 3'b111);
    eng_done_i = 1'b1;
    strm_done_i = 3'b011;
    cnt_out_i = 11'd10;
    step();
    eng_done_i = 1'b0;
    strm_done_i = 3'b000;
    chk("D_wait_enable", eng_enable_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("D_hold_enable", eng_enable_o, 1'b1);
      chk("D_hold_nodone", done_o, 1'b0);
    end
    strm_done_i = 3'b100;
    step();
    strm_done_i = 3'b000;
    chk("D_update_enable", eng_enable_o, 1'b0);
    chk("D_update_busy", busy_o, 1'b1);
    step();
    chk("D_done", done_o, 1'b1);
    step();

    // nb_iter=0 runs one tile; count mismatch flags cnt_err
    clr_counts();
    kick(16'd0);
    do_tile(32'h1000, 32'h2000, 32'h3000, 16'd0, 2, 11'd9);
    chk("E_done_one_tile", done_o, 1'b1);
    chk("E_cnt_err", cnt_err_o, 1'b1);
    step(); step(); step();
    chk("E_cnt_err_sticky", cnt_err_o, 1'b1);
    chk("E_done_cnt", done_cnt, 1);

    // Abort during tile 1 of 3, then a clean restart
    clr_counts();
    kick(16'd3);
    chk("F_cnt_err_cleared", cnt_err_o, 1'b0);
    do_tile(32'h1000, 32'h2000, 32'h3000, 16'd0, 1, 11'd10);
    step();
    chk("F_tile1_compute", eng_enable_o, 1'b1);
    chk("F_tile1_addr", in_pel_addr_o, 32'h1100);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("F_abort_busy", busy_o, 1'b0);
    chk("F_abort_enable", eng_enable_o, 1'b0);
    chk("F_abort_addr", in_size_addr_o, 32'h0);
    chk("F_abort_idx", iter_idx_o, 16'd0);
    chk("F_abort_req", strm_req_o, 3'b000);
    step(); step();
    chk("F_abort_no_done", done_cnt, 0);
    kick(16'd1);
    do_tile(32'h1000, 32'h2000, 32'h3000, 16'd0, 3, 11'd10);
    chk("F_restart_done", done_o, 1'b1);
    step();
    chk("F_restart_idle", busy_o, 1'b0);
    chk("F_restart_addr", out_pel_addr_o, 32'h3100);
    chk("F_restart_cnt_err", cnt_err_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
